// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction fetch unit: ARM encoding constants
// used by branch predecode, PC arithmetic constants and the fetch FSM state
// type.
//
// Optional feature macro (consumed by the files that import this package):
//   IFU_STATIC_BRANCH_EN - enables static redirection on unconditional B/BL.
// ---------------------------------------------------------------------------
package ifu_pkg;

  // ARM condition field value meaning "always"
  localparam logic [3:0]  COND_AL      = 4'hE;
  // Bits [27:25] of an ARM B/BL instruction
  localparam logic [2:0]  OP_BRANCH    = 3'b101;
  // Sequential fetch increment (one 32-bit word)
  localparam logic [31:0] PC_STEP      = 32'd4;
  // ARM reads PC as the instruction address plus 8
  localparam logic [31:0] ARM_PC_AHEAD = 32'd8;

  // FETCH streams normally; BUBBLE is the one empty cycle after a redirect
  typedef enum logic {
    FETCH  = 1'b0,
    BUBBLE = 1'b1
  } ifu_state_e;

  // Byte offset of a B/BL instruction: imm24 sign-extended, times four
  function automatic logic [31:0] branch_offset(input logic [23:0] imm24);
    return {{6{imm24[23]}}, imm24, 2'b00};
  endfunction

endpackage : ifu_pkg

// File: rtl/branch_predecode.sv
// ---------------------------------------------------------------------------
// branch_predecode
// Combinational predecode of the instruction word currently returned by the
// ROM. Flags unconditional B/BL and computes its target address so fetch can
// redirect itself without waiting for execute.
//
// The module only exists when IFU_STATIC_BRANCH_EN is defined; in the default
// build there is no predecode logic at all.
//
// Ports:
//   instruction      in  32  ROM word being captured this cycle
//   pc               in  32  address that word was fetched from
//   is_static_branch out  1  word is B/BL with the AL condition
//   target           out 32  pc + 8 + sign_extend(imm24) * 4
// ---------------------------------------------------------------------------
`ifdef IFU_STATIC_BRANCH_EN
module branch_predecode
  import ifu_pkg::*;
(
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  output logic        is_static_branch,
  output logic [31:0] target
);

  // Only the always-taken form is safe to follow before the flags are known
  assign is_static_branch = (instruction[31:28] == COND_AL) &&
                            (instruction[27:25] == OP_BRANCH);

  // ARM branch targets are relative to the instruction address plus 8
  assign target = pc + ARM_PC_AHEAD + branch_offset(instruction[23:0]);

endmodule : branch_predecode
`endif

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Reading side of the combinational instruction ROM. Holds the PC, drives the
// ROM address from it, captures each returned word into the IF/ID register
// and hands it to decode over a valid/ready handshake. Execute-stage
// redirects reload the PC and leave one bubble cycle.
//
// Optional feature macro:
//   IFU_STATIC_BRANCH_EN - predecode the captured word; unconditional B/BL
//                          redirect fetch immediately and set id_pred_taken.
//
// Parameters:
//   RESET_PC         PC value loaded on reset (bits [1:0] must be 0)
//
// Ports:
//   clk              in   1  clock, rising edge
//   rst              in   1  asynchronous active-high reset
//   imem_addr        out 32  ROM address, always the PC register
//   imem_data        in  32  ROM word for imem_addr, same cycle
//   id_valid         out  1  IF/ID register holds an instruction
//   id_ready         in   1  decode accepts the instruction this cycle
//   id_instr         out 32  captured instruction
//   id_pc            out 32  address of the captured instruction
//   id_pred_taken    out  1  fetch already followed this static branch
//   redirect_valid   in   1  execute-stage PC redirect
//   redirect_target  in  32  new PC, low two bits forced to zero
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_pred_taken,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);

  ifu_state_e  r_state;
  ifu_state_e  w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_id_valid;
  logic        w_id_valid_next;
  logic [31:0] r_id_instr;
  logic [31:0] w_id_instr_next;
  logic [31:0] r_id_pc;
  logic [31:0] w_id_pc_next;
  logic        r_id_pred_taken;
  logic        w_id_pred_taken_next;

  logic        w_advance;
  logic [31:0] w_seq_pc;
  logic        w_capture_pred;
  logic [31:0] w_redirect_pc;

  // Word-align the external target by masking rather than slicing
  assign w_redirect_pc = redirect_target & ~32'h0000_0003;

  // The slot is empty during BUBBLE, so fetch always captures there
  assign w_advance = (r_state == BUBBLE) || !r_id_valid || id_ready;

`ifdef IFU_STATIC_BRANCH_EN
  logic        w_is_static_branch;
  logic [31:0] w_branch_target;

  branch_predecode u_branch_predecode (
    .instruction      (imem_data),
    .pc               (r_pc),
    .is_static_branch (w_is_static_branch),
    .target           (w_branch_target)
  );

  assign w_seq_pc       = w_is_static_branch ? w_branch_target : (r_pc + PC_STEP);
  assign w_capture_pred = w_is_static_branch;
`else
  assign w_seq_pc       = r_pc + PC_STEP;
  assign w_capture_pred = 1'b0;
`endif

  // Next-state and next-register logic: redirect beats advance beats hold.
  // A redirect leaves the captured word in place but marks the slot empty.
  always_comb begin
    w_state_next         = r_state;
    w_pc_next            = r_pc;
    w_id_valid_next      = r_id_valid;
    w_id_instr_next      = r_id_instr;
    w_id_pc_next         = r_id_pc;
    w_id_pred_taken_next = r_id_pred_taken;

    if (redirect_valid) begin
      w_pc_next       = w_redirect_pc;
      w_id_valid_next = 1'b0;
      w_state_next    = BUBBLE;
    end else if (w_advance) begin
      w_id_instr_next      = imem_data;
      w_id_pc_next         = r_pc;
      w_id_pred_taken_next = w_capture_pred;
      w_id_valid_next      = 1'b1;
      w_pc_next            = w_seq_pc;
      w_state_next         = FETCH;
    end
  end

  // State, PC and IF/ID registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= FETCH;
      r_pc            <= RESET_PC;
      r_id_valid      <= 1'b0;
      r_id_instr      <= 32'h0;
      r_id_pc         <= 32'h0;
      r_id_pred_taken <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_pc            <= w_pc_next;
      r_id_valid      <= w_id_valid_next;
      r_id_instr      <= w_id_instr_next;
      r_id_pc         <= w_id_pc_next;
      r_id_pred_taken <= w_id_pred_taken_next;
    end
  end

  assign imem_addr     = r_pc;
  assign id_valid      = r_id_valid;
  assign id_instr      = r_id_instr;
  assign id_pc         = r_id_pc;
  assign id_pred_taken = r_id_pred_taken;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Drives instruction_fetch_unit from a ROM array kept in the bench and
// compares every output after every clock edge against a cycle-level model
// of the fetch rules (PC, IF/ID slot contents). Directed steps cover reset,
// streaming, backpressure, redirect, static branch, PC wrap and mid-stream
// reset; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] ROM_LIMIT  = 32'h0000_0100;
  localparam logic [31:0] BRANCH_WORD = 32'hEAFF_FFEC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pred_taken   (id_pred_taken),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  always #5 clk = ~clk;

  // Instruction ROM: 64 words at 0x00..0xFC, zero elsewhere
  logic [31:0] rom [0:63];
  bit          romLoaded = 1'b0;

  function automatic logic [31:0] romRead(input logic [31:0] addr);
    if (addr < ROM_LIMIT) return rom[addr[7:2]];
    return 32'h0;
  endfunction

  always @(imem_addr or romLoaded) imem_data = romRead(imem_addr);

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: what decode should see and where fetch should point
  logic [31:0] mPc;
  logic        mValid;
  logic [31:0] mInstr;
  logic [31:0] mIdPc;
  logic        mPred;

  function automatic bit isStaticBranch(input logic [31:0] word);
`ifdef IFU_STATIC_BRANCH_EN
    return (word[31:28] == 4'hE) && (word[27:25] == 3'b101);
`else
    return 1'b0;
`endif
  endfunction

  task automatic modelReset();
    mPc    = RESET_PC;
    mValid = 1'b0;
    mInstr = 32'h0;
    mIdPc  = 32'h0;
    mPred  = 1'b0;
  endtask

  // One clock edge of fetch behaviour, from the inputs seen before the edge
  task automatic modelStep(input bit ready, input bit rv, input logic [31:0] target);
    logic [31:0] word;
    int          offset;
    if (rv) begin
      mPc    = {target[31:2], 2'b00};
      mValid = 1'b0;
    end else if (!mValid || ready) begin
      word   = romRead(mPc);
      mInstr = word;
      mIdPc  = mPc;
      mValid = 1'b1;
      mPred  = isStaticBranch(word);
      if (mPred) begin
        offset = $signed(word[23:0]) * 4;
        mPc    = mPc + 32'd8 + 32'(offset);
      end else begin
        mPc    = mPc + 32'd4;
      end
    end
  endtask

  task automatic checkField(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string step);
    checkField({step, ".imem_addr"}, imem_addr, mPc);
    checkField({step, ".id_valid"}, {31'b0, id_valid}, {31'b0, mValid});
    checkField({step, ".id_instr"}, id_instr, mInstr);
    checkField({step, ".id_pc"}, id_pc, mIdPc);
    checkField({step, ".id_pred_taken"}, {31'b0, id_pred_taken}, {31'b0, mPred});
  endtask

  // Drive one cycle of inputs, clock it, advance the model, then sample
  task automatic applyStimulus(input bit ready, input bit rv, input logic [31:0] target);
    id_ready        = ready;
    redirect_valid  = rv;
    redirect_target = target;
    @(posedge clk);
    modelStep(ready, rv, target);
    #1;
  endtask

  initial begin
    logic [31:0] heldInstr;
    rst             = 1'b1;
    id_ready        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;

    for (int i = 0; i < 64; i++) begin
      rom[i] = $urandom;
      if (rom[i][31:28] == 4'hE && rom[i][27:25] == 3'b101) rom[i][25] = 1'b0;
    end
    rom[32'h4C >> 2] = BRANCH_WORD;
    romLoaded = 1'b1;
    modelReset();

    // Reset state
    #12;
    checkOutput("reset");
    checkField("reset.addr_const", imem_addr, 32'h0);
    rst = 1'b0;

    // Streaming from RESET_PC
    applyStimulus(1, 0, 32'h0);
    checkOutput("stream0");
    checkField("stream0.id_pc_const", id_pc, 32'h00);
    checkField("stream0.instr_rom", id_instr, rom[0]);
    applyStimulus(1, 0, 32'h0);
    checkOutput("stream1");
    applyStimulus(1, 0, 32'h0);
    checkOutput("stream2");
    checkField("stream2.id_pc_const", id_pc, 32'h08);

    // Backpressure holding 0x08
    heldInstr = id_instr;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 32'h0);
      checkOutput("hold");
      checkField("hold.addr_const", imem_addr, 32'h0C);
      checkField("hold.instr_stable", id_instr, heldInstr);
    end
    applyStimulus(1, 0, 32'h0);
    checkOutput("release");
    checkField("release.id_pc_const", id_pc, 32'h0C);

    // Redirect while stalled: the stalled word is dropped
    applyStimulus(0, 0, 32'h0);
    checkOutput("stall");
    applyStimulus(0, 1, 32'h73);
    checkOutput("redirect");
    checkField("redirect.addr_const", imem_addr, 32'h70);
    checkField("redirect.valid_low", {31'b0, id_valid}, 32'h0);
    applyStimulus(1, 0, 32'h0);
    checkOutput("redirect_fill");
    checkField("redirect_fill.id_pc_const", id_pc, 32'h70);

    // Static branch at 0x4C
    applyStimulus(1, 1, 32'h4C);
    checkOutput("to_branch");
    applyStimulus(1, 0, 32'h0);
    checkOutput("branch_capture");
    checkField("branch_capture.instr", id_instr, BRANCH_WORD);
`ifdef IFU_STATIC_BRANCH_EN
    checkField("branch_capture.pred", {31'b0, id_pred_taken}, 32'h1);
`else
    checkField("branch_capture.pred", {31'b0, id_pred_taken}, 32'h0);
`endif
    applyStimulus(1, 0, 32'h0);
    checkOutput("branch_next");
`ifdef IFU_STATIC_BRANCH_EN
    checkField("branch_next.id_pc_const", id_pc, 32'h04);
`else
    checkField("branch_next.id_pc_const", id_pc, 32'h50);
`endif

    // Back-to-back redirects: the last one wins
    applyStimulus(1, 1, 32'h20);
    checkOutput("b2b0");
    applyStimulus(1, 1, 32'h31);
    checkOutput("b2b1");
    applyStimulus(1, 0, 32'h0);
    checkOutput("b2b_fill");
    checkField("b2b_fill.id_pc_const", id_pc, 32'h30);

    // PC wrap from the top of the address space
    applyStimulus(1, 1, 32'hFFFF_FFFC);
    checkOutput("wrap_redirect");
    applyStimulus(1, 0, 32'h0);
    checkOutput("wrap_top");
    checkField("wrap_top.addr_const", imem_addr, 32'h0);
    applyStimulus(1, 0, 32'h0);
    checkOutput("wrap_zero");
    checkField("wrap_zero.id_pc_const", id_pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    32'($urandom_range(0, 511)));
      checkOutput("random");
    end

    // Asynchronous reset in the middle of a cycle
    applyStimulus(0, 0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("mid_reset");
    checkField("mid_reset.valid_low", {31'b0, id_valid}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("mid_reset_held");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 32'h0);
      checkOutput("post_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_instruction_fetch_unit
